// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM control unit: FSM states,
// instruction field codes, ALU operation encodings and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_VECEX  = 4'd10
    } mc_state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_VEC = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Map a data-processing cmd onto the ALU operation; unknown cmds add.
    function automatic logic [2:0] alu_op(input logic [3:0] cmd);
        logic [2:0] op;
        case (cmd)
            CMD_ADD: op = ALU_ADD;
            CMD_SUB: op = ALU_SUB;
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            CMD_CMP: op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// Condition-field evaluator: decides from Cond and the stored NZCV flags
// whether the current instruction is allowed to take effect.
module mc_condcheck
    import mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = flags_i;

    // Standard ARM condition table; the NV encoding behaves as always.
    always_comb begin
        cond_ex_o = 1'b1;
        case (cond_i)
            COND_EQ: cond_ex_o = z_s;
            COND_NE: cond_ex_o = ~z_s;
            COND_CS: cond_ex_o = c_s;
            COND_CC: cond_ex_o = ~c_s;
            COND_MI: cond_ex_o = n_s;
            COND_PL: cond_ex_o = ~n_s;
            COND_VS: cond_ex_o = v_s;
            COND_VC: cond_ex_o = ~v_s;
            COND_HI: cond_ex_o = c_s & ~z_s;
            COND_LS: cond_ex_o = ~c_s | z_s;
            COND_GE: cond_ex_o = (n_s == v_s);
            COND_LT: cond_ex_o = (n_s != v_s);
            COND_GT: cond_ex_o = ~z_s & (n_s == v_s);
            COND_LE: cond_ex_o = z_s | (n_s != v_s);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing each instruction,
// NZCV flag register, condition gating and a per-lane vector sequencer.
module mc_controller
    import mc_pkg::*;
#(
    parameter  int VEC_LANES = 4,
    parameter  int ALUCTRL_W = 3,
    localparam int LW        = (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 VecWrite,
    output logic [LW-1:0]        VecLane,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Busy
);

    localparam logic [LW-1:0] LAST_LANE = LW'(VEC_LANES - 1);

    mc_state_e     state_q, state_d;
    logic [3:0]    flags_q, flags_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          vcond_q, vcond_d;

    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] cmd_s;
    logic [3:0] cond_s;
    logic       cond_ex_s;
    logic       is_cmp_s, is_logic_s;
    logic       flagw_nzcv_s, flagw_nz_s;
    logic [2:0] alu_s;
    logic       unused_instr_s;

    assign op_s    = Instr[27:26];
    assign funct_s = Instr[25:20];
    assign cmd_s   = funct_s[4:1];
    assign cond_s  = Instr[31:28];

    // Register-address fields are consumed by the datapath, not here.
    assign unused_instr_s = ^Instr[19:12];

    assign is_cmp_s     = (cmd_s == CMD_CMP);
    assign is_logic_s   = (cmd_s == CMD_AND) || (cmd_s == CMD_ORR);
    assign flagw_nzcv_s = is_cmp_s | (funct_s[0] & ~is_logic_s);
    assign flagw_nz_s   = funct_s[0] & is_logic_s;

    mc_condcheck u_condcheck (
        .cond_i    (cond_s),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex_s)
    );

    // State, flag, lane and vector-condition registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            lane_q  <= '0;
            vcond_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            lane_q  <= lane_d;
            vcond_q <= vcond_d;
        end
    end

    // Next-state sequencing for every instruction class.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_VEC:  state_d = S_VECEX;
                    default: state_d = funct_s[5] ? S_EXECI : S_EXECR;
                endcase
            end
            S_MEMADR: state_d = funct_s[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_VECEX:  state_d = (lane_q == LAST_LANE) ? S_FETCH : S_VECEX;
            default:  state_d = S_FETCH;
        endcase
    end

    // Flag update in ALUWB (logical ops keep C and V), lane stepping and
    // one-shot capture of the vector condition while decoding.
    always_comb begin
        flags_d = flags_q;
        lane_d  = lane_q;
        vcond_d = vcond_q;
        if ((state_q == S_ALUWB) && cond_ex_s) begin
            if (flagw_nzcv_s) begin
                flags_d = ALUFlags;
            end else if (flagw_nz_s) begin
                flags_d = {ALUFlags[3:2], flags_q[1:0]};
            end else begin
                flags_d = flags_q;
            end
        end else begin
            flags_d = flags_q;
        end
        if (state_q == S_DECODE) begin
            lane_d  = '0;
            vcond_d = cond_ex_s;
        end else if (state_q == S_VECEX) begin
            lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LW'(1);
        end else begin
            lane_d = lane_q;
        end
    end

    // Per-state datapath controls; while reset is low all enables are held
    // off and the selects sit at their FETCH values.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        VecWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_s     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                alu_s   = funct_s[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex_s;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_s;
            end
            S_EXECR:  alu_s = alu_op(cmd_s);
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_s   = alu_op(cmd_s);
            end
            S_ALUWB: begin
                alu_s    = alu_op(cmd_s);
                RegWrite = cond_ex_s & ~is_cmp_s;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_s;
                RegWrite  = cond_ex_s & funct_s[4];
            end
            S_VECEX: begin
                ALUSrcB  = funct_s[5] ? 2'b01 : 2'b00;
                alu_s    = alu_op(cmd_s);
                VecWrite = vcond_q;
            end
            default: alu_s = ALU_ADD;
        endcase
        if (!reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            VecWrite  = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            alu_s     = ALU_ADD;
        end else begin
            alu_s = alu_s;
        end
    end

    assign ALUControl = ALUCTRL_W'(alu_s);
    assign ImmSrc     = op_s;
    assign RegSrc     = {(op_s == OP_MEM) & ~funct_s[0], (op_s == OP_BR)};
    assign VecLane    = lane_q;
    assign Busy       = (state_q != S_FETCH);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: scalar sequences on a 4-lane instance,
// vector sequencing on 4-, 1- and 8-lane instances driven in lockstep.
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:12] instr;
    logic [3:0]  alu_flags;

    int checks = 0;
    int errors = 0;

    // 4-lane instance outputs
    logic a_pcw, a_adr, a_memw, a_irw, a_regw, a_vecw, a_busy;
    logic [1:0] a_lane;
    logic [1:0] a_res, a_sa, a_sb, a_imm, a_rs;
    logic [2:0] a_alu;
    // 1-lane instance outputs
    logic b_pcw, b_adr, b_memw, b_irw, b_regw, b_vecw, b_busy;
    logic [0:0] b_lane;
    logic [1:0] b_res, b_sa, b_sb, b_imm, b_rs;
    logic [2:0] b_alu;
    // 8-lane instance outputs
    logic c_pcw, c_adr, c_memw, c_irw, c_regw, c_vecw, c_busy;
    logic [2:0] c_lane;
    logic [1:0] c_res, c_sa, c_sb, c_imm, c_rs;
    logic [2:0] c_alu;

    mc_controller #(.VEC_LANES(4), .ALUCTRL_W(3)) u_dut4 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_memw), .IRWrite(a_irw),
        .RegWrite(a_regw), .VecWrite(a_vecw), .VecLane(a_lane),
        .ResultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ImmSrc(a_imm),
        .RegSrc(a_rs), .ALUControl(a_alu), .Busy(a_busy)
    );

    mc_controller #(.VEC_LANES(1), .ALUCTRL_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_memw), .IRWrite(b_irw),
        .RegWrite(b_regw), .VecWrite(b_vecw), .VecLane(b_lane),
        .ResultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ImmSrc(b_imm),
        .RegSrc(b_rs), .ALUControl(b_alu), .Busy(b_busy)
    );

    mc_controller #(.VEC_LANES(8), .ALUCTRL_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(c_pcw), .AdrSrc(c_adr), .MemWrite(c_memw), .IRWrite(c_irw),
        .RegWrite(c_regw), .VecWrite(c_vecw), .VecLane(c_lane),
        .ResultSrc(c_res), .ALUSrcA(c_sa), .ALUSrcB(c_sb), .ImmSrc(c_imm),
        .RegSrc(c_rs), .ALUControl(c_alu), .Busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:12] mk(input logic [3:0] cond, input logic [1:0] op,
                                        input logic [5:0] funct);
        return {cond, op, funct, 8'h00};
    endfunction

    initial begin
        reset     = 1'b0;
        alu_flags = 4'b0000;
        // STR, AL, P=1 U=1 L=0
        instr     = mk(4'b1110, 2'b01, 6'b011000);
        tick();
        tick();
        chk("rst_pcwrite", 32'(a_pcw), 32'd0);
        chk("rst_irwrite", 32'(a_irw), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_alusrcb", 32'(a_sb), 32'd2);

        reset = 1'b1;
        #1;
        chk("fetch_irwrite", 32'(a_irw), 32'd1);
        chk("fetch_pcwrite", 32'(a_pcw), 32'd1);
        tick();
        chk("str_decode_busy", 32'(a_busy), 32'd1);
        tick();
        chk("str_memadr_alu", 32'(a_alu), 32'd0);
        chk("str_memadr_srcb", 32'(a_sb), 32'd1);
        tick();
        chk("str_memwr_memwrite", 32'(a_memw), 32'd1);
        chk("str_memwr_adrsrc", 32'(a_adr), 32'd1);
        reset = 1'b0;
        #1;
        chk("str_rst_memwrite", 32'(a_memw), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("str_rst_hold_memwrite", 32'(a_memw), 32'd0);
            chk("str_rst_hold_busy", 32'(a_busy), 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("post_rst_busy", 32'(a_busy), 32'd0);
        chk("post_rst_flags", 32'(u_dut4.flags_q), 32'd0);
        chk("post_rst_irwrite", 32'(a_irw), 32'd1);

        // ADDS immediate, result zero
        instr     = mk(4'b1110, 2'b00, 6'b101001);
        alu_flags = 4'b0100;
        tick();
        tick();
        chk("adds_execi_srcb", 32'(a_sb), 32'd1);
        chk("adds_execi_alu", 32'(a_alu), 32'd0);
        tick();
        chk("adds_aluwb_regwrite", 32'(a_regw), 32'd1);
        chk("adds_aluwb_alu", 32'(a_alu), 32'd0);
        chk("adds_aluwb_flags_old", 32'(u_dut4.flags_q), 32'd0);
        tick();
        chk("adds_done_busy", 32'(a_busy), 32'd0);
        chk("adds_flags", 32'(u_dut4.flags_q), 32'h4);

        // CMP register, sets Z and C
        instr     = mk(4'b1110, 2'b00, 6'b010101);
        alu_flags = 4'b0110;
        tick();
        tick();
        chk("cmp_execr_alu", 32'(a_alu), 32'd1);
        chk("cmp_execr_srcb", 32'(a_sb), 32'd0);
        tick();
        chk("cmp_aluwb_regwrite", 32'(a_regw), 32'd0);
        tick();
        chk("cmp_done_busy", 32'(a_busy), 32'd0);
        chk("cmp_flags", 32'(u_dut4.flags_q), 32'h6);

        // BEQ taken
        instr = mk(4'b0000, 2'b10, 6'b000000);
        tick();
        tick();
        chk("beq_pcwrite", 32'(a_pcw), 32'd1);
        chk("beq_regwrite", 32'(a_regw), 32'd0);
        tick();
        chk("beq_done_busy", 32'(a_busy), 32'd0);

        // BNE not taken
        instr = mk(4'b0001, 2'b10, 6'b000000);
        tick();
        tick();
        chk("bne_pcwrite", 32'(a_pcw), 32'd0);
        tick();

        // BL always
        instr = mk(4'b1110, 2'b10, 6'b010000);
        tick();
        tick();
        chk("bl_pcwrite", 32'(a_pcw), 32'd1);
        chk("bl_regwrite", 32'(a_regw), 32'd1);
        chk("bl_regsrc", 32'(a_rs), 32'd1);
        tick();

        // ANDS: only N and Z change, C/V kept from CMP
        instr     = mk(4'b1110, 2'b00, 6'b000001);
        alu_flags = 4'b1001;
        tick();
        tick();
        chk("ands_execr_alu", 32'(a_alu), 32'd2);
        tick();
        tick();
        chk("ands_flags", 32'(u_dut4.flags_q), 32'hA);

        // LDR, L=1 U=0
        instr = mk(4'b1110, 2'b01, 6'b010001);
        tick();
        tick();
        chk("ldr_memadr_alu", 32'(a_alu), 32'd1);
        tick();
        chk("ldr_memrd_adrsrc", 32'(a_adr), 32'd1);
        chk("ldr_memrd_memwrite", 32'(a_memw), 32'd0);
        tick();
        chk("ldr_memwb_regwrite", 32'(a_regw), 32'd1);
        chk("ldr_memwb_resultsrc", 32'(a_res), 32'd1);
        tick();
        chk("ldr_done_busy", 32'(a_busy), 32'd0);

        // Vector ADD, AL, on all three lane counts
        reset = 1'b0;
        tick();
        reset = 1'b1;
        instr = mk(4'b1110, 2'b11, 6'b001000);
        tick();
        chk("vec_decode_busy", 32'(a_busy), 32'd1);
        tick();
        chk("vec_alu", 32'(a_alu), 32'd0);
        for (int c = 0; c <= 8; c++) begin
            if (c < 4) begin
                chk("vec4_lane", 32'(a_lane), 32'(c));
                chk("vec4_vecwrite", 32'(a_vecw), 32'd1);
                chk("vec4_busy", 32'(a_busy), 32'd1);
            end else if (c == 4) begin
                chk("vec4_done_busy", 32'(a_busy), 32'd0);
            end
            if (c < 1) begin
                chk("vec1_lane", 32'(b_lane), 32'd0);
                chk("vec1_vecwrite", 32'(b_vecw), 32'd1);
            end else if (c == 1) begin
                chk("vec1_done_busy", 32'(b_busy), 32'd0);
            end
            if (c < 8) begin
                chk("vec8_lane", 32'(c_lane), 32'(c));
                chk("vec8_vecwrite", 32'(c_vecw), 32'd1);
                chk("vec8_busy", 32'(c_busy), 32'd1);
            end else begin
                chk("vec8_done_busy", 32'(c_busy), 32'd0);
            end
            tick();
        end

        // Vector EQ with Z clear: no lane writes, same duration
        reset = 1'b0;
        tick();
        reset = 1'b1;
        instr = mk(4'b0000, 2'b11, 6'b001000);
        tick();
        tick();
        for (int c = 0; c <= 8; c++) begin
            if (c < 4) begin
                chk("vecf4_vecwrite", 32'(a_vecw), 32'd0);
                chk("vecf4_lane", 32'(a_lane), 32'(c));
                chk("vecf4_busy", 32'(a_busy), 32'd1);
            end else if (c == 4) begin
                chk("vecf4_done_busy", 32'(a_busy), 32'd0);
            end
            if (c < 1) begin
                chk("vecf1_vecwrite", 32'(b_vecw), 32'd0);
            end else if (c == 1) begin
                chk("vecf1_done_busy", 32'(b_busy), 32'd0);
            end
            if (c < 8) begin
                chk("vecf8_vecwrite", 32'(c_vecw), 32'd0);
                chk("vecf8_busy", 32'(c_busy), 32'd1);
            end else begin
                chk("vecf8_done_busy", 32'(c_busy), 32'd0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM datapath, the successor to the single-cycle `controller`. It sequences each instruction through a Moore FSM and generates per-cycle datapath enables and mux selects. It holds the NZCV flag register, evaluates the condition field, and executes vector instructions one lane per cycle over `VEC_LANES` cycles. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- `VEC_LANES`, 4: vector lanes; ≥1. Lane index width `LW = max(1,$clog2(VEC_LANES))`.
- `ALUCTRL_W`, 3: width of `ALUControl`; ≥3.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: synchronous, active-low (0 = reset); one clock; no asynchronous path.
- `Instr  in  20`: `Instr[31:12]`, valid from the IR after FETCH.
- `ALUFlags  in  4`: NZCV from the ALU in the current cycle.
- `PCWrite  out  1`: PC load enable.
- `AdrSrc  out  1`: memory address select (0 = PC, 1 = ALU result register).
- `MemWrite  out  1`: data store enable.
- `IRWrite  out  1`: instruction register load.
- `RegWrite  out  1`: register file write.
- `VecWrite  out  1`: vector register file lane write.
- `VecLane  out  LW`: lane currently executing.
- `ResultSrc  out  2`: result select (00 = ALUOut, 01 = Data, 10 = ALUResult).
- `ALUSrcA  out  2`: ALU A select (00 = Rn, 01 = PC, 10 = ALUOut).
- `ALUSrcB  out  2`: ALU B select (00 = Rm/ext, 01 = imm, 10 = const 4).
- `ImmSrc  out  2`: immediate extend select (`Op`).
- `RegSrc  out  2`: register address selects, as in `controller`.
- `ALUControl  out  ALUCTRL_W`: ALU operation.
- `Busy  out  1`: 1 in every state except FETCH.

## Operation
- Fields:
  - `Op = Instr[27:26]`: 00 data-proc, 01 memory, 10 branch, 11 vector.
  - `Funct = Instr[25:20]`; `cmd = Funct[4:1]`; `S = Funct[0]`; `I = Funct[5]`; `Cond = Instr[31:28]`.
- ALU decode:
  - cmd 0100 → ADD 000; 0010 → SUB 001; 0000 → AND 010; 1100 → ORR 011; 1010 (CMP) → SUB with no register write.
  - Any other cmd → ADD. Upper `ALUControl` bits are 0.
- `FlagW`: arithmetic ops with S set write NZCV; logical ops with S set write NZ only; CMP always writes NZCV.
- `CondEx` is combinational from `Cond` and the registered `Flags`, using standard ARM EQ…AL semantics. 1111 is treated as AL.
- Gating by `CondEx`: `RegWrite`, `MemWrite`, `VecWrite`, branch `PCWrite` and flag updates. FETCH `PCWrite` and `IRWrite` are never gated.
- FSM states and transitions:
  - FETCH → DECODE.
  - DECODE: Op 01 → MEMADR; Op 10 → BRANCH; Op 11 → VECEX; Op 00 → EXECI when `I` = 1, else EXECR.
  - MEMADR: `Funct[0]` (L) = 1 → MEMRD, else → MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR / EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
  - VECEX stays in VECEX while `lane != VEC_LANES-1`, then → FETCH.
- State outputs:
  - FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=01, `ALUSrcB`=10, ADD, `ResultSrc`=10, `PCWrite`=1.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=10, ADD (computes PC+8).
  - MEMADR: `ALUSrcB`=01; ADD when U (`Funct[3]`) = 1, else SUB.
  - MEMRD: `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegWrite`.
  - MEMWR: `AdrSrc`=1, `MemWrite`.
  - ALUWB: `ResultSrc`=00, `RegWrite` unless CMP, flag update.
  - BRANCH: `ALUSrcB`=01, ADD, `ResultSrc`=10, `PCWrite`. When `Funct[4]` (L) = 1, also `RegWrite` to R14 and `RegSrc[0]`=1.
  - VECEX: `VecWrite`, `VecLane`=lane, ALU op from cmd. Vector ops never update flags.
- Lane counter: cleared on DECODE→VECEX; increments each VECEX cycle; wraps to 0 on exit.
- Condition for vector ops is sampled once, in DECODE, into `vcond`. All lanes use `vcond`, so a false condition suppresses every lane while still taking `VEC_LANES` cycles.

## Timing
- Reset:
  - `reset`=0 at an edge gives state=FETCH, `Flags`=0000, lane=0, `vcond`=0.
  - While `reset` is low, every enable (`PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `VecWrite`) is forced to 0. Selects take their FETCH values.
  - Reset mid-instruction aborts it; no partial write occurs in the reset cycle.
- Outputs are combinational from state and `Instr`. Flags and lane are registered.
- Cycle counts:
  - Data-proc/CMP: 4 (FETCH, DECODE, EXEC, ALUWB).
  - LDR: 5. STR: 4. B/BL: 3. Vector: 2 + `VEC_LANES`.
- Flags written in ALUWB are visible to `CondEx` from the next FETCH. There is no same-cycle bypass.
- `Instr` must be held stable by the IR from DECODE until the return to FETCH.

## Structure
- `mc_pkg`: state enum, `Op` codes, cmd codes, ALU op constants, cond codes.
- Sub-module `mc_condcheck`: `Cond` × `Flags` → `CondEx`, purely combinational.
- FSM, decode, flag register and lane counter live in `mc_controller`.

## Test plan
- Reset held 3 cycles during MEMWR of an STR → `MemWrite`=0 throughout; after release, state=FETCH and `Flags`=0.
- ADDS giving a zero result → 4 cycles; in ALUWB, `RegWrite`=1 and `ALUControl`=000; Z=1 from the next FETCH.
- CMP setting Z, then BEQ → CMP has `RegWrite`=0 in ALUWB; BEQ asserts `PCWrite` in BRANCH and returns to FETCH after 3 cycles. BNE in the same situation asserts no `PCWrite` in BRANCH.
- LDR (L=1, U=0) → `ALUControl`=SUB in MEMADR; `AdrSrc`=1 in MEMRD; `RegWrite`, `ResultSrc`=01 in MEMWB; 5 cycles total.
- Vector ADD with `VEC_LANES`=4 → `VecLane` 0,1,2,3 on consecutive cycles with `VecWrite`=1 each; `Busy` drops after 6 cycles. Repeat with `VEC_LANES`=1 and 8.
- Vector op with a false condition (EQ, Z=0) → `VecWrite`=0 on all lanes, still 2 + `VEC_LANES` cycles.
